// File: rtl/leaf_stream_bridge.sv
// leaf_stream_bridge: NUM_CH independent FWFT FIFOs between a leaf
// interface and its kernel; output release waits for a latched start.
//
// Ports:
//   ap_clk, ap_rst_n  clock, synchronous active-low reset
//   ap_start          start request, latched into `started`
//   s_data/s_vld/s_ack  upstream channels (packed, DATA_W per channel)
//   m_data/m_vld/m_ack  downstream channels (packed, DATA_W per channel)
//   flush             per-channel synchronous FIFO clear
//   level             per-channel occupancy, DEPTH_LOG2+1 bits each
//   xfer_cnt          per-channel downstream transfer count, CNT_W bits each
//   started           latched start flag
module leaf_stream_bridge #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 3,
  parameter int CNT_W      = 32
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             ap_start,
  input  logic [NUM_CH*DATA_W-1:0]         s_data,
  input  logic [NUM_CH-1:0]                s_vld,
  output logic [NUM_CH-1:0]                s_ack,
  output logic [NUM_CH*DATA_W-1:0]         m_data,
  output logic [NUM_CH-1:0]                m_vld,
  input  logic [NUM_CH-1:0]                m_ack,
  input  logic [NUM_CH-1:0]                flush,
  output logic [NUM_CH*(DEPTH_LOG2+1)-1:0] level,
  output logic [NUM_CH*CNT_W-1:0]          xfer_cnt,
  output logic                             started
);

  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic started_q;
  logic started_d;

  always_comb begin
    started_d = started_q | ap_start;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      started_q <= 1'b0;
    end else begin
      started_q <= started_d;
    end
  end

  assign started = started_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              full;
    logic              empty;
    logic              ack;
    logic              vld;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    // Extra pointer MSB tells full from empty when the index bits match.
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign ack  = ~full & ~flush[i] & ap_rst_n;
    assign vld  = ~empty & started_q;
    assign push = s_vld[i] & ack;
    // A flush discards any pop in the same cycle, so it is not counted.
    assign pop  = vld & m_ack[i] & ~flush[i];
    assign head = mem_q[rd_ptr_q[PW-2:0]];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush[i]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end else begin
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (pop) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    // Storage needs no reset; push is already blocked during reset.
    always_ff @(posedge ap_clk) begin
      if (push) begin
        mem_q[wr_ptr_q[PW-2:0]] <= s_data[i*DATA_W +: DATA_W];
      end
    end

    assign s_ack[i] = ack;
    assign m_vld[i] = vld;
    // Empty FIFOs drive zero so stale or unwritten storage never leaks.
    assign m_data[i*DATA_W +: DATA_W] = empty ? '0 : head;
    assign level[i*PW +: PW]          = wr_ptr_q - rd_ptr_q;
    assign xfer_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// Directed bench for leaf_stream_bridge: reset, pre-fill, streaming,
// full-with-pop scoreboard, flush and counter wrap / mid-run reset.
module tb_leaf_stream_bridge;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int DL = 3;
  localparam int CW = 4;
  localparam int PW = DL + 1;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n;
  logic               ap_start;
  logic [NC*DW-1:0]   s_data;
  logic [NC-1:0]      s_vld;
  logic [NC-1:0]      s_ack;
  logic [NC*DW-1:0]   m_data;
  logic [NC-1:0]      m_vld;
  logic [NC-1:0]      m_ack;
  logic [NC-1:0]      flush;
  logic [NC*PW-1:0]   level;
  logic [NC*CW-1:0]   xfer_cnt;
  logic               started;

  int total = 0;
  int bad   = 0;
  logic [CW-1:0] cnt1_exp;

  leaf_stream_bridge #(
    .NUM_CH(NC), .DATA_W(DW), .DEPTH_LOG2(DL), .CNT_W(CW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .s_data(s_data), .s_vld(s_vld), .s_ack(s_ack),
    .m_data(m_data), .m_vld(m_vld), .m_ack(m_ack),
    .flush(flush), .level(level), .xfer_cnt(xfer_cnt),
    .started(started)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [PW-1:0] lvl(int i);
    return level[i*PW +: PW];
  endfunction

  function automatic logic [CW-1:0] cnt(int i);
    return xfer_cnt[i*CW +: CW];
  endfunction

  function automatic logic [DW-1:0] md(int i);
    return m_data[i*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; ap_start = 1'b0; s_data = '0;
    s_vld = '0; m_ack = '0; flush = '0;
    tick(); tick();
    total++; if (s_ack !== 4'h0) begin bad++; $display("FAIL rst_s_ack got=%h exp=0", s_ack); end
    total++; if (m_vld !== 4'h0) begin bad++; $display("FAIL rst_m_vld got=%h exp=0", m_vld); end
    total++; if (level !== '0) begin bad++; $display("FAIL rst_level got=%h exp=0", level); end
    total++; if (xfer_cnt !== '0) begin bad++; $display("FAIL rst_cnt got=%h exp=0", xfer_cnt); end
    total++; if (started !== 1'b0) begin bad++; $display("FAIL rst_started got=%b exp=0", started); end
    total++; if (m_data !== '0) begin bad++; $display("FAIL rst_m_data got=%h exp=0", m_data); end
    ap_rst_n = 1'b1;
    #1;
    total++; if (s_ack !== 4'hf) begin bad++; $display("FAIL rel_s_ack got=%h exp=f", s_ack); end
    total++; if (m_vld !== 4'h0) begin bad++; $display("FAIL rel_m_vld got=%h exp=0", m_vld); end
  endtask

  task automatic test_prefill();
    m_ack = 4'hf;
    for (int k = 0; k < 8; k++) begin
      s_data[0 +: DW] = 32'h100 + k;
      s_vld[0] = 1'b1;
      tick();
    end
    s_vld = '0;
    total++; if (lvl(0) !== 4'd8) begin bad++; $display("FAIL pre_level got=%0d exp=8", lvl(0)); end
    total++; if (s_ack[0] !== 1'b0) begin bad++; $display("FAIL pre_s_ack got=%b exp=0", s_ack[0]); end
    total++; if (m_vld[0] !== 1'b0) begin bad++; $display("FAIL pre_m_vld got=%b exp=0", m_vld[0]); end
    total++; if (started !== 1'b0) begin bad++; $display("FAIL pre_started got=%b exp=0", started); end
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    total++; if (started !== 1'b1) begin bad++; $display("FAIL start_flag got=%b exp=1", started); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (m_vld[0] !== 1'b1 || md(0) !== 32'h100 + k) begin
        bad++;
        $display("FAIL pre_out%0d got vld=%b data=%h exp vld=1 data=%h", k, m_vld[0], md(0), 32'h100 + k);
      end
      tick();
    end
    total++; if (cnt(0) !== 4'd8) begin bad++; $display("FAIL pre_cnt got=%0d exp=8", cnt(0)); end
    total++; if (lvl(0) !== 4'd0) begin bad++; $display("FAIL pre_drained got=%0d exp=0", lvl(0)); end
    total++; if (m_vld[0] !== 1'b0) begin bad++; $display("FAIL pre_empty_vld got=%b exp=0", m_vld[0]); end
    total++; if (started !== 1'b1) begin bad++; $display("FAIL start_hold got=%b exp=1", started); end
  endtask

  task automatic test_stream();
    m_ack = 4'hf;
    for (int k = 0; k < 20; k++) begin
      s_data[2*DW +: DW] = 32'h2000 + k;
      s_vld[2] = 1'b1;
      #1;
      total++;
      if (s_ack[2] !== 1'b1) begin bad++; $display("FAIL str_ack%0d got=%b exp=1", k, s_ack[2]); end
      if (k > 0) begin
        total++;
        if (m_vld[2] !== 1'b1 || md(2) !== 32'h2000 + k - 1 || lvl(2) !== 4'd1) begin
          bad++;
          $display("FAIL str_out%0d got vld=%b data=%h lvl=%0d exp vld=1 data=%h lvl=1",
                   k, m_vld[2], md(2), lvl(2), 32'h2000 + k - 1);
        end
      end
      tick();
    end
    s_vld = '0;
    total++; if (md(2) !== 32'h2013) begin bad++; $display("FAIL str_last got=%h exp=2013", md(2)); end
    tick();
    total++; if (lvl(2) !== 4'd0) begin bad++; $display("FAIL str_level got=%0d exp=0", lvl(2)); end
    total++; if (cnt(2) !== 4'd4) begin bad++; $display("FAIL str_cnt got=%0d exp=4", cnt(2)); end
  endtask

  task automatic test_full_pop();
    int lm = 0;
    int pops = 0;
    int guard = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] wd = 32'h3000;
    bit u, p, ma;
    for (int c = 0; c < 108; c++) begin
      ma = (c < 8) ? 1'b0 : 1'($urandom_range(0, 1));
      m_ack[1] = ma;
      s_vld[1] = 1'b1;
      s_data[DW +: DW] = wd;
      #1;
      u = (lm < 8);
      p = (lm > 0) && ma;
      total++;
      if (s_ack[1] !== u || m_vld[1] !== (lm > 0)) begin
        bad++;
        $display("FAIL full_hs%0d got ack=%b vld=%b exp ack=%b vld=%b", c, s_ack[1], m_vld[1], u, lm > 0);
      end
      if (lm > 0) begin
        total++;
        if (md(1) !== q[0]) begin bad++; $display("FAIL full_data%0d got=%h exp=%h", c, md(1), q[0]); end
      end
      tick();
      if (p) begin void'(q.pop_front()); pops++; lm--; end
      if (u) begin q.push_back(wd); wd++; lm++; end
      total++;
      if (lvl(1) !== PW'(lm)) begin bad++; $display("FAIL full_level%0d got=%0d exp=%0d", c, lvl(1), lm); end
    end
    s_vld[1] = 1'b0;
    m_ack[1] = 1'b1;
    while (lm > 0 && guard < 16) begin
      total++;
      if (m_vld[1] !== 1'b1 || md(1) !== q[0]) begin
        bad++;
        $display("FAIL drain_data got vld=%b data=%h exp vld=1 data=%h", m_vld[1], md(1), q[0]);
      end
      tick();
      void'(q.pop_front()); pops++; lm--; guard++;
    end
    cnt1_exp = CW'(pops);
    total++; if (lvl(1) !== 4'd0) begin bad++; $display("FAIL drain_level got=%0d exp=0", lvl(1)); end
    total++; if (cnt(1) !== cnt1_exp) begin bad++; $display("FAIL full_cnt got=%0d exp=%0d", cnt(1), cnt1_exp); end
    m_ack = '0;
  endtask

  task automatic test_flush();
    m_ack = '0;
    s_vld = '0;
    for (int k = 0; k < 5; k++) begin
      s_data[3*DW +: DW] = 32'h4000 + k;
      s_data[0 +: DW]    = 32'h5000 + k;
      s_vld[3] = 1'b1;
      s_vld[0] = (k < 2);
      tick();
    end
    s_vld = '0;
    total++; if (lvl(3) !== 4'd5) begin bad++; $display("FAIL fl_pre3 got=%0d exp=5", lvl(3)); end
    total++; if (lvl(0) !== 4'd2) begin bad++; $display("FAIL fl_pre0 got=%0d exp=2", lvl(0)); end
    flush[3] = 1'b1;
    s_vld[3] = 1'b1;
    s_data[3*DW +: DW] = 32'hdead;
    m_ack[3] = 1'b1;
    #1;
    total++; if (s_ack[3] !== 1'b0) begin bad++; $display("FAIL fl_ack got=%b exp=0", s_ack[3]); end
    total++; if (m_vld[3] !== 1'b1) begin bad++; $display("FAIL fl_vld got=%b exp=1", m_vld[3]); end
    total++; if (s_ack[0] !== 1'b1) begin bad++; $display("FAIL fl_other_ack got=%b exp=1", s_ack[0]); end
    tick();
    flush = '0;
    s_vld = '0;
    m_ack = '0;
    #1;
    total++; if (lvl(3) !== 4'd0) begin bad++; $display("FAIL fl_level got=%0d exp=0", lvl(3)); end
    total++; if (m_vld[3] !== 1'b0) begin bad++; $display("FAIL fl_post_vld got=%b exp=0", m_vld[3]); end
    total++; if (cnt(3) !== 4'd0) begin bad++; $display("FAIL fl_cnt3 got=%0d exp=0", cnt(3)); end
    total++;
    if (lvl(0) !== 4'd2 || lvl(1) !== 4'd0 || lvl(2) !== 4'd0) begin
      bad++;
      $display("FAIL fl_levels got=%h exp=0002", level[3*PW-1:0]);
    end
    total++;
    if (cnt(0) !== 4'd8 || cnt(1) !== cnt1_exp || cnt(2) !== 4'd4) begin
      bad++;
      $display("FAIL fl_counts got=%0d/%0d/%0d exp=8/%0d/4", cnt(0), cnt(1), cnt(2), cnt1_exp);
    end
    s_data[3*DW +: DW] = 32'h4100;
    s_vld[3] = 1'b1;
    tick();
    s_vld = '0;
    total++;
    if (lvl(3) !== 4'd1 || md(3) !== 32'h4100) begin
      bad++;
      $display("FAIL fl_refill got lvl=%0d data=%h exp lvl=1 data=4100", lvl(3), md(3));
    end
    m_ack = 4'b1001;
    total++; if (md(0) !== 32'h5000) begin bad++; $display("FAIL fl_ch0_a got=%h exp=5000", md(0)); end
    tick();
    total++; if (md(0) !== 32'h5001) begin bad++; $display("FAIL fl_ch0_b got=%h exp=5001", md(0)); end
    tick();
    m_ack = '0;
    total++; if (lvl(0) !== 4'd0) begin bad++; $display("FAIL fl_ch0_lvl got=%0d exp=0", lvl(0)); end
    total++; if (cnt(0) !== 4'd10 || cnt(3) !== 4'd1) begin bad++; $display("FAIL fl_post_cnt got=%0d/%0d exp=10/1", cnt(0), cnt(3)); end
  endtask

  task automatic test_wrap_reset();
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    total++; if (xfer_cnt !== '0) begin bad++; $display("FAIL wr_clear got=%h exp=0", xfer_cnt); end
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    m_ack[0] = 1'b1;
    for (int k = 0; k < 17; k++) begin
      s_data[0 +: DW] = 32'h600 + k;
      s_vld[0] = 1'b1;
      tick();
    end
    total++;
    if (cnt(0) !== 4'd0 || lvl(0) !== 4'd1) begin
      bad++;
      $display("FAIL wr_16 got cnt=%0d lvl=%0d exp cnt=0 lvl=1", cnt(0), lvl(0));
    end
    s_vld = '0;
    tick();
    total++; if (cnt(0) !== 4'd1) begin bad++; $display("FAIL wr_17 got=%0d exp=1", cnt(0)); end
    m_ack = '0;
    for (int k = 0; k < 3; k++) begin
      s_data[0 +: DW] = 32'h700 + k;
      s_vld[0] = 1'b1;
      tick();
    end
    s_vld = '0;
    total++;
    if (lvl(0) !== 4'd3 || m_vld[0] !== 1'b1) begin
      bad++;
      $display("FAIL wr_fill got lvl=%0d vld=%b exp lvl=3 vld=1", lvl(0), m_vld[0]);
    end
    m_ack = 4'hf;
    s_vld[0] = 1'b1;
    ap_rst_n = 1'b0;
    #1;
    total++; if (s_ack !== 4'h0) begin bad++; $display("FAIL mr_s_ack got=%h exp=0", s_ack); end
    tick();
    total++; if (level !== '0) begin bad++; $display("FAIL mr_level got=%h exp=0", level); end
    total++; if (started !== 1'b0) begin bad++; $display("FAIL mr_started got=%b exp=0", started); end
    total++; if (m_vld !== 4'h0) begin bad++; $display("FAIL mr_m_vld got=%h exp=0", m_vld); end
    total++; if (xfer_cnt !== '0) begin bad++; $display("FAIL mr_cnt got=%h exp=0", xfer_cnt); end
    total++; if (m_data !== '0) begin bad++; $display("FAIL mr_m_data got=%h exp=0", m_data); end
    ap_rst_n = 1'b1;
    s_vld = '0;
    m_ack = '0;
    tick();
    total++;
    if (s_ack !== 4'hf || m_vld !== 4'h0) begin
      bad++;
      $display("FAIL mr_release got ack=%h vld=%h exp ack=f vld=0", s_ack, m_vld);
    end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_stream();
    test_full_pop();
    test_flush();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
